// File: rtl/nec_ir_pkg.sv
// Shared constants for the NEC IR receiver: state codes, error codes, default timing.
package nec_ir_pkg;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BCNT_W = 5;

  // FSM state codes
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LEAD_H   = 3'd1;
  localparam logic [2:0] ST_LEAD_L   = 3'd2;
  localparam logic [2:0] ST_BIT_H    = 3'd3;
  localparam logic [2:0] ST_BIT_L    = 3'd4;
  localparam logic [2:0] ST_STOP_H   = 3'd5;
  localparam logic [2:0] ST_RPT_STOP = 3'd6;

  // Error cause codes reported on o_err_code
  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_LEADER   = 3'd1;
  localparam logic [2:0] ERR_BIT      = 3'd2;
  localparam logic [2:0] ERR_CHECKSUM = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

  // Default NEC timing, in ticks of 1 us
  localparam int unsigned DEF_CLK_HZ        = 50_000_000;
  localparam int unsigned DEF_TICK_HZ       = 1_000_000;
  localparam int unsigned DEF_FILT_LEN      = 4;
  localparam int unsigned DEF_LEAD_H_MIN_US = 8000;
  localparam int unsigned DEF_LEAD_H_MAX_US = 10000;
  localparam int unsigned DEF_LEAD_L_MIN_US = 4000;
  localparam int unsigned DEF_LEAD_L_MAX_US = 5000;
  localparam int unsigned DEF_RPT_L_MIN_US  = 2000;
  localparam int unsigned DEF_RPT_L_MAX_US  = 2750;
  localparam int unsigned DEF_BIT_H_MIN_US  = 400;
  localparam int unsigned DEF_BIT_H_MAX_US  = 750;
  localparam int unsigned DEF_BIT0_L_MIN_US = 400;
  localparam int unsigned DEF_BIT0_L_MAX_US = 800;
  localparam int unsigned DEF_BIT1_L_MIN_US = 1400;
  localparam int unsigned DEF_BIT1_L_MAX_US = 1900;
  localparam int unsigned DEF_TIMEOUT_US    = 12000;

  // Inclusive window test on a measured width
  function automatic logic in_win(input logic [CNT_W-1:0] w,
                                  input int unsigned lo,
                                  input int unsigned hi);
    return (w >= CNT_W'(lo)) && (w <= CNT_W'(hi));
  endfunction

endpackage

// File: rtl/nec_ir_rx_v2_front.sv
// IR pin front end: synchroniser, tick generator, glitch filter, edge pulses.
module ir_rx_front #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TICK_HZ   = 1_000_000,
  parameter bit          INVERT_IN = 1'b1,
  parameter int unsigned FILT_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_ir_rxb,
  output logic tick_c,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned RUN_W = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;

  logic [1:0]       sync_q;
  logic [DIV_W-1:0] div_q;
  logic [RUN_W-1:0] run_q;
  logic             level_q;
  logic             sample_c;
  logic             flip_c;

  // Two-flop synchroniser, preset to the idle pin level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= INVERT_IN ? 2'b11 : 2'b00;
    else     sync_q <= {sync_q[0], i_ir_rxb};
  end

  // 1 = mark after optional inversion
  assign sample_c = sync_q[1] ^ INVERT_IN;

  // Tick divider wrapping at DIV-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         div_q <= '0;
    else if (tick_c) div_q <= '0;
    else             div_q <= div_q + DIV_W'(1);
  end

  assign tick_c = (div_q == DIV_W'(DIV - 1));
  assign flip_c = tick_c && (sample_c != level_q) && (run_q == RUN_W'(FILT_LEN - 1));
  assign rise_c = flip_c && !level_q;
  assign fall_c = flip_c && level_q;

  // Level changes only after FILT_LEN consecutive differing tick samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      run_q   <= '0;
    end else if (tick_c) begin
      if (sample_c == level_q) begin
        run_q <= '0;
      end else if (flip_c) begin
        level_q <= ~level_q;
        run_q   <= '0;
      end else begin
        run_q <= run_q + RUN_W'(1);
      end
    end
  end

endmodule

// File: rtl/nec_ir_rx_v2.sv
// NEC IR receiver top: width counter, decode FSM, shift register, checksum and outputs.
module nec_ir_rx_v2
  import nec_ir_pkg::*;
#(
  parameter int unsigned CLK_HZ        = DEF_CLK_HZ,
  parameter int unsigned TICK_HZ       = DEF_TICK_HZ,
  parameter bit          INVERT_IN     = 1'b1,
  parameter int unsigned FILT_LEN      = DEF_FILT_LEN,
  parameter int unsigned LEAD_H_MIN_US = DEF_LEAD_H_MIN_US,
  parameter int unsigned LEAD_H_MAX_US = DEF_LEAD_H_MAX_US,
  parameter int unsigned LEAD_L_MIN_US = DEF_LEAD_L_MIN_US,
  parameter int unsigned LEAD_L_MAX_US = DEF_LEAD_L_MAX_US,
  parameter int unsigned RPT_L_MIN_US  = DEF_RPT_L_MIN_US,
  parameter int unsigned RPT_L_MAX_US  = DEF_RPT_L_MAX_US,
  parameter int unsigned BIT_H_MIN_US  = DEF_BIT_H_MIN_US,
  parameter int unsigned BIT_H_MAX_US  = DEF_BIT_H_MAX_US,
  parameter int unsigned BIT0_L_MIN_US = DEF_BIT0_L_MIN_US,
  parameter int unsigned BIT0_L_MAX_US = DEF_BIT0_L_MAX_US,
  parameter int unsigned BIT1_L_MIN_US = DEF_BIT1_L_MIN_US,
  parameter int unsigned BIT1_L_MAX_US = DEF_BIT1_L_MAX_US,
  parameter int unsigned TIMEOUT_US    = DEF_TIMEOUT_US,
  parameter bit          CHK_CMD       = 1'b1,
  parameter bit          CHK_ADDR      = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ir_rxb,
  output logic [DATA_W-1:0] o_data,
  output logic [7:0]        o_addr,
  output logic [7:0]        o_cmd,
  output logic              o_valid,
  output logic              o_repeat,
  output logic              o_err,
  output logic [2:0]        o_err_code,
  output logic              o_busy
);

  logic              tick_c, rise_c, fall_c, edge_c;
  logic [CNT_W-1:0]  width_q;
  logic [2:0]        state_q, state_d;
  logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d, data_d;
  logic              have_frame_q, have_frame_d;
  logic              valid_d, repeat_d;
  logic [2:0]        fail_c;
  logic              timeout_c, bit0_c, bit1_c, mark_ok_c, chk_ok_c;

  ir_rx_front #(
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .INVERT_IN(INVERT_IN),
    .FILT_LEN (FILT_LEN)
  ) u_front (
    .clk     (clk),
    .rst     (rst),
    .i_ir_rxb(i_ir_rxb),
    .tick_c  (tick_c),
    .rise_c  (rise_c),
    .fall_c  (fall_c)
  );

  assign edge_c = rise_c || fall_c;

  // Tick-based width counter, saturating, cleared on every filtered edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       width_q <= '0;
    else if (edge_c)                               width_q <= '0;
    else if (tick_c && (width_q != {CNT_W{1'b1}})) width_q <= width_q + CNT_W'(1);
  end

  assign timeout_c = tick_c && (state_q != ST_IDLE) && (width_q > CNT_W'(TIMEOUT_US));
  assign mark_ok_c = in_win(width_q, BIT_H_MIN_US, BIT_H_MAX_US);
  assign bit0_c    = in_win(width_q, BIT0_L_MIN_US, BIT0_L_MAX_US);
  assign bit1_c    = in_win(width_q, BIT1_L_MIN_US, BIT1_L_MAX_US);
  assign chk_ok_c  = (!CHK_CMD  || (shift_q[31:24] == ~shift_q[23:16])) &&
                     (!CHK_ADDR || (shift_q[15:8]  == ~shift_q[7:0]));

  // Next-state and output decode; an edge in the same tick masks a timeout
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_d       = o_data;
    have_frame_d = have_frame_q;
    valid_d      = 1'b0;
    repeat_d     = 1'b0;
    fail_c       = ERR_NONE;
    if (edge_c) begin
      case (state_q)
        ST_IDLE: begin
          if (rise_c) state_d = ST_LEAD_H;
        end
        ST_LEAD_H: begin
          if (fall_c && in_win(width_q, LEAD_H_MIN_US, LEAD_H_MAX_US)) state_d = ST_LEAD_L;
          else fail_c = ERR_LEADER;
        end
        ST_LEAD_L: begin
          if (rise_c && in_win(width_q, LEAD_L_MIN_US, LEAD_L_MAX_US)) begin
            state_d   = ST_BIT_H;
            bit_cnt_d = '0;
          end else if (rise_c && in_win(width_q, RPT_L_MIN_US, RPT_L_MAX_US)) begin
            state_d = ST_RPT_STOP;
          end else begin
            fail_c = ERR_LEADER;
          end
        end
        ST_BIT_H: begin
          if (fall_c && mark_ok_c) state_d = ST_BIT_L;
          else fail_c = ERR_BIT;
        end
        ST_BIT_L: begin
          if (rise_c && (bit0_c || bit1_c)) begin
            shift_d = {~bit0_c, shift_q[DATA_W-1:1]};
            if (bit_cnt_q == BCNT_W'(DATA_W - 1)) begin
              state_d = ST_STOP_H;
            end else begin
              bit_cnt_d = bit_cnt_q + BCNT_W'(1);
              state_d   = ST_BIT_H;
            end
          end else begin
            fail_c = ERR_BIT;
          end
        end
        ST_STOP_H: begin
          if (fall_c && mark_ok_c) begin
            state_d = ST_IDLE;
            if (chk_ok_c) begin
              data_d       = shift_q;
              valid_d      = 1'b1;
              have_frame_d = 1'b1;
            end else begin
              fail_c = ERR_CHECKSUM;
            end
          end else begin
            fail_c = ERR_BIT;
          end
        end
        ST_RPT_STOP: begin
          if (fall_c && mark_ok_c) begin
            state_d  = ST_IDLE;
            repeat_d = have_frame_q;
          end else begin
            fail_c = ERR_BIT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout_c) begin
      fail_c = ERR_TIMEOUT;
    end
    if (fail_c != ERR_NONE) state_d = ST_IDLE;
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      have_frame_q <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_repeat     <= 1'b0;
      o_err        <= 1'b0;
      o_err_code   <= ERR_NONE;
      o_busy       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      have_frame_q <= have_frame_d;
      o_data       <= data_d;
      o_valid      <= valid_d;
      o_repeat     <= repeat_d;
      o_err        <= (fail_c != ERR_NONE);
      if (fail_c != ERR_NONE) o_err_code <= fail_c;
      o_busy       <= (state_d != ST_IDLE);
    end
  end

  assign o_addr = o_data[7:0];
  assign o_cmd  = o_data[23:16];

endmodule

// File: tb/tb_nec_ir_rx_v2.sv
// Self-checking bench for nec_ir_rx_v2: directed NEC scenarios plus random frames vs a frame-level model.
`timescale 1ns/1ps
module tb_nec_ir_rx_v2;

  // NEC timing compressed 40x (1 tick = 1 us) to keep the run short; window/nominal ratios kept.
  localparam int unsigned LEAD_MARK = 225;
  localparam int unsigned LEAD_SPC  = 112;
  localparam int unsigned RPT_SPC   = 56;
  localparam int unsigned MARK      = 14;
  localparam int unsigned SPC0      = 14;
  localparam int unsigned SPC1      = 42;
  localparam int unsigned GAP       = 40;
  localparam int unsigned TOUT      = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ir  = 1'b1;
  logic [31:0] o_data;
  logic [7:0]  o_addr, o_cmd;
  logic        o_valid, o_repeat, o_err, o_busy;
  logic [2:0]  o_err_code;

  int n_cmp = 0, n_bad = 0;
  int n_valid = 0, n_repeat = 0, n_err = 0;
  int s_valid, s_repeat, s_err;

  // Reference model state
  bit          m_have = 1'b0;
  logic [31:0] m_data = '0;
  logic [2:0]  m_code = '0;

  nec_ir_rx_v2 #(
    .CLK_HZ(2_000_000), .TICK_HZ(1_000_000), .INVERT_IN(1'b1), .FILT_LEN(4),
    .LEAD_H_MIN_US(200), .LEAD_H_MAX_US(250),
    .LEAD_L_MIN_US(100), .LEAD_L_MAX_US(125),
    .RPT_L_MIN_US(50),   .RPT_L_MAX_US(68),
    .BIT_H_MIN_US(10),   .BIT_H_MAX_US(18),
    .BIT0_L_MIN_US(10),  .BIT0_L_MAX_US(20),
    .BIT1_L_MIN_US(35),  .BIT1_L_MAX_US(47),
    .TIMEOUT_US(TOUT), .CHK_CMD(1'b1), .CHK_ADDR(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .i_ir_rxb(ir),
    .o_data(o_data), .o_addr(o_addr), .o_cmd(o_cmd),
    .o_valid(o_valid), .o_repeat(o_repeat), .o_err(o_err),
    .o_err_code(o_err_code), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse counters and mutual exclusion of the three pulse outputs
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid)  n_valid++;
      if (o_repeat) n_repeat++;
      if (o_err)    n_err++;
      if (o_valid || o_repeat || o_err)
        check("pulse_excl", 32'(int'(o_valid) + int'(o_repeat) + int'(o_err)), 32'd1);
    end
  end

  // Hold a line level (mark = pin low) for a number of 1 us ticks
  task automatic hold(input bit mark, input int unsigned us);
    ir = ~mark;
    repeat (2 * us) @(negedge clk);
  endtask

  task automatic send_lead(input bit glitch);
    if (glitch) begin
      hold(1'b1, 100); hold(1'b0, 2); hold(1'b1, LEAD_MARK - 102);
    end else begin
      hold(1'b1, LEAD_MARK);
    end
    hold(1'b0, LEAD_SPC);
  endtask

  task automatic send_bits(input logic [31:0] w, input int nbits, input bit glitch);
    int unsigned spc;
    for (int i = 0; i < nbits; i++) begin
      hold(1'b1, MARK);
      spc = w[i] ? SPC1 : SPC0;
      if (glitch && i == 3) begin
        hold(1'b0, 5); hold(1'b1, 3); hold(1'b0, spc - 8);
      end else begin
        hold(1'b0, spc);
      end
    end
  endtask

  task automatic send_frame(input logic [31:0] w, input int nbits, input bit glitch);
    send_lead(glitch);
    send_bits(w, nbits, glitch);
    if (nbits == 32) hold(1'b1, MARK);
    else             hold(1'b0, TOUT + 100);
    hold(1'b0, GAP);
  endtask

  task automatic snap();
    s_valid = n_valid; s_repeat = n_repeat; s_err = n_err;
  endtask

  task automatic expect_out(input string tag, input int ev, input int er, input int ee);
    check({tag, "_valid"},  32'(n_valid - s_valid),   32'(ev));
    check({tag, "_repeat"}, 32'(n_repeat - s_repeat), 32'(er));
    check({tag, "_err"},    32'(n_err - s_err),       32'(ee));
    check({tag, "_data"},   o_data, m_data);
    check({tag, "_addr"},   32'(o_addr), 32'(m_data[7:0]));
    check({tag, "_cmd"},    32'(o_cmd),  32'(m_data[23:16]));
    check({tag, "_code"},   32'(o_err_code), 32'(m_code));
    check({tag, "_busy"},   32'(o_busy), 32'd0);
  endtask

  // Frame outcome from the protocol rules: truncated -> timeout, else command checksum decides
  task automatic do_frame(input string tag, input logic [31:0] w, input int nbits, input bit glitch);
    int ev, ee;
    ev = 0; ee = 0;
    if (nbits < 32) begin
      ee = 1; m_code = 3'd4;
    end else if (w[31:24] == ~w[23:16]) begin
      ev = 1; m_data = w; m_have = 1'b1;
    end else begin
      ee = 1; m_code = 3'd3;
    end
    snap();
    send_frame(w, nbits, glitch);
    expect_out(tag, ev, 0, ee);
  endtask

  task automatic do_repeat(input string tag);
    snap();
    hold(1'b1, LEAD_MARK); hold(1'b0, RPT_SPC); hold(1'b1, MARK); hold(1'b0, GAP);
    expect_out(tag, 0, m_have ? 1 : 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  o_data, 32'd0);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_rpt"},   32'(o_repeat), 32'd0);
    check({tag, "_err"},   32'(o_err), 32'd0);
    check({tag, "_code"},  32'(o_err_code), 32'd0);
    check({tag, "_busy"},  32'(o_busy), 32'd0);
  endtask

  initial begin
    logic [7:0]  a, c, b1, b3;
    logic [31:0] w;
    repeat (4) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    hold(1'b0, GAP);

    do_repeat("rpt_no_frame");
    do_frame("frame_45", 32'hBA45FF00, 32, 1'b0);
    do_repeat("rpt_after_frame");
    do_frame("bad_cksum", 32'hBB45FF00, 32, 1'b0);

    for (int k = 0; k < 4; k++) begin
      a  = 8'($urandom_range(0, 255));
      c  = 8'($urandom_range(0, 255));
      b1 = ($urandom_range(0, 1) == 0) ? ~a : 8'($urandom_range(0, 255));
      b3 = ($urandom_range(0, 3) == 0) ? (~c ^ 8'($urandom_range(1, 255))) : ~c;
      w  = {b3, c, b1, a};
      do_frame("rand_frame", w, 32, 1'b0);
      if ($urandom_range(0, 2) == 0) do_repeat("rand_rpt");
    end

    do_frame("glitch", 32'hBA45FF00, 32, 1'b1);
    do_frame("timeout", 32'h12345678, 16, 1'b0);
    do_frame("post_tout", 32'hE11E807F, 32, 1'b0);

    // Abort during bit 10 with a 5-cycle reset
    snap();
    send_lead(1'b0);
    send_bits(32'h40BF10EF, 10, 1'b0);
    hold(1'b1, MARK);
    ir = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_all_zero("in_reset");
    end
    rst = 1'b0;
    m_have = 1'b0; m_data = '0; m_code = '0;
    hold(1'b0, GAP);
    expect_out("rst_abort", 0, 0, 0);
    do_repeat("rpt_after_rst");
    do_frame("post_rst", 32'h40BF10EF, 32, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
